// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file geometry and arbiter FSM encoding for the
// register-file write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches i_req starting one past i_ptr,
// wrapping modulo NUM_REQ, and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  function automatic logic [PTR_W-1:0] wrap_idx(input int v);
    return PTR_W'(v % NUM_REQ);
  endfunction

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // Offset NUM_REQ wraps back to the last winner, which is searched last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!o_any && i_req[wrap_idx(int'(i_ptr) + k)]) begin
        o_any                               = 1'b1;
        o_grant[wrap_idx(int'(i_ptr) + k)] = 1'b1;
        o_idx                               = wrap_idx(int'(i_ptr) + k);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: zero-fills all registers after reset, then
// grants one writeback source per cycle round-robin with registered outputs.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*REG_DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [REG_ADDR_W-1:0]          rf_wa,
  output logic [REG_DATA_W-1:0]          rf_wd,
  output logic                           rf_we,
  output logic                           busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(REG_COUNT - 1);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [REG_ADDR_W-1:0] r_ctr;
  logic [PTR_W-1:0]      r_ptr;

  logic [NUM_REQ-1:0]    w_grant;
  logic [PTR_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_arb_en;
  logic                  w_hs;
  logic [REG_ADDR_W-1:0] w_addr [NUM_REQ];
  logic [REG_DATA_W-1:0] w_data [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr[gi] = req_addr[gi*REG_ADDR_W +: REG_ADDR_W];
      assign w_data[gi] = req_data[gi*REG_DATA_W +: REG_DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Grants only land on valid bits, so any grant while enabled is a handshake.
  assign w_arb_en  = (r_state == RUN) && !rst;
  assign req_ready = w_arb_en ? w_grant : '0;
  assign w_hs      = w_arb_en && w_any;
  assign busy      = (r_state == CLEAR) || (rst && (CLEAR_ON_RESET != 0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == CLEAR && r_ctr == LAST_REG) begin
      w_state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr <= '0;
      r_ptr <= PTR_INIT;
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (r_state == CLEAR) begin
      rf_we <= 1'b1;
      rf_wa <= r_ctr;
      rf_wd <= '0;
      r_ctr <= r_ctr + REG_ADDR_W'(1);
    end else if (w_hs) begin
      r_ptr <= w_idx;
      rf_wa <= w_addr[w_idx];
      rf_wd <= w_data[w_idx];
      // Writes to $zero are accepted but never reach the register file.
      rf_we <= (w_addr[w_idx] != ZERO_REG);
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized self-checking bench for regfile_write_arbiter with a round-robin
// reference model; a second instance covers the no-clear configuration.
module tb_regfile_write_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with the zero-fill sequence enabled
  logic           rst;
  logic [N-1:0]   valid;
  logic [4:0]     a [N];
  logic [31:0]    d [N];
  logic [N*5-1:0] addr_bus;
  logic [N*32-1:0] data_bus;
  logic [N-1:0]   ready;
  logic [4:0]     wa;
  logic [31:0]    wd;
  logic           we;
  logic           busy;

  // Instance that goes straight to arbitration
  logic           rst0;
  logic [N-1:0]   valid0;
  logic [4:0]     a0;
  logic [31:0]    d0;
  logic [N-1:0]   ready0;
  logic [4:0]     wa0;
  logic [31:0]    wd0;
  logic           we0;
  logic           busy0;

  always_comb begin
    addr_bus = '0;
    data_bus = '0;
    for (int i = 0; i < N; i++) begin
      addr_bus[i*5 +: 5]   = a[i];
      data_bus[i*32 +: 32] = d[i];
    end
  end

  regfile_write_arbiter #(.NUM_REQ(N), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .req_valid(valid), .req_addr(addr_bus), .req_data(data_bus),
    .req_ready(ready), .rf_wa(wa), .rf_wd(wd), .rf_we(we), .busy(busy)
  );

  regfile_write_arbiter #(.NUM_REQ(N), .CLEAR_ON_RESET(0)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(valid0), .req_addr({10'd0, a0}), .req_data({64'd0, d0}),
    .req_ready(ready0), .rf_wa(wa0), .rf_wd(wd0), .rf_we(we0), .busy(busy0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: index of the last granted requester and the expected write port
  int          m_last;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_accept(input int g);
    if (g >= 0) begin
      m_last = g;
      m_we   = (a[g] != 5'd0);
      m_wa   = a[g];
      m_wd   = d[g];
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst0 = 1'b1;
    valid = '1; valid0 = 3'b001;
    for (int i = 0; i < N; i++) begin
      a[i] = 5'(5 + i);
      d[i] = 32'(10 + i);
    end
    a0 = 5'd9; d0 = 32'h1234;
    repeat (3) step();
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", we); end
    n_cmp++; if (wa !== 5'd0) begin n_bad++; $display("FAIL reset_wa: got %0d want 0", wa); end
    n_cmp++; if (wd !== 32'd0) begin n_bad++; $display("FAIL reset_wd: got %0h want 0", wd); end
    n_cmp++; if (ready !== '0) begin n_bad++; $display("FAIL reset_ready: got %b want 000", ready); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy_noclear: got %b want 0", busy0); end
    n_cmp++; if (ready0 !== '0) begin n_bad++; $display("FAIL reset_ready_noclear: got %b want 000", ready0); end
    $display("reset: we=%b wa=%0d wd=%0h ready=%b busy=%b busy0=%b", we, wa, wd, ready, busy, busy0);
  endtask

  task automatic test_no_clear();
    rst0 = 1'b0;
    #1;
    n_cmp++; if (ready0 !== 3'b001) begin n_bad++; $display("FAIL noclear_ready: got %b want 001", ready0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL noclear_busy: got %b want 0", busy0); end
    step();
    valid0 = '0;
    n_cmp++; if (we0 !== 1'b1 || wa0 !== 5'd9 || wd0 !== 32'h1234) begin
      n_bad++; $display("FAIL noclear_write: got we=%b wa=%0d wd=%0h want 1/9/1234", we0, wa0, wd0);
    end
    $display("noclear: first grant write we=%b wa=%0d wd=%0h", we0, wa0, wd0);
  endtask

  task automatic run_clear(input string tag, input logic [N-1:0] last_ready);
    for (int k = 0; k < 32; k++) begin
      step();
      n_cmp++;
      if (we !== 1'b1 || wa !== 5'(k) || wd !== 32'd0) begin
        n_bad++; $display("FAIL %s_write%0d: got we=%b wa=%0d wd=%0h want 1/%0d/0", tag, k, we, wa, wd, k);
      end
      n_cmp++;
      if (busy !== (k != 31)) begin
        n_bad++; $display("FAIL %s_busy%0d: got %b want %b", tag, k, busy, k != 31);
      end
      n_cmp++;
      if (ready !== ((k == 31) ? last_ready : '0)) begin
        n_bad++; $display("FAIL %s_ready%0d: got %b want %b", tag, k, ready, (k == 31) ? last_ready : '0);
      end
      $display("%s: cycle %0d we=%b wa=%0d busy=%b ready=%b", tag, k, we, wa, busy, ready);
    end
    m_last = N - 1;
    m_we = 1'b1; m_wa = 5'd31; m_wd = 32'd0;
  endtask

  task automatic test_clear();
    rst = 1'b0;
    run_clear("clear", 3'b001);
  endtask

  task automatic test_rotation();
    int g;
    valid = '1;
    for (int i = 0; i < 9; i++) begin
      #1;
      g = pick(valid, m_last);
      n_cmp++;
      if (ready !== onehot(i % N)) begin
        n_bad++; $display("FAIL rot_ready%0d: got %b want %b", i, ready, onehot(i % N));
      end
      model_accept(g);
      step();
      n_cmp++;
      if (we !== 1'b1 || wa !== m_wa || wd !== m_wd) begin
        n_bad++; $display("FAIL rot_write%0d: got we=%b wa=%0d wd=%0h want 1/%0d/%0h", i, we, wa, wd, m_wa, m_wd);
      end
      $display("rotation: grant %0d -> we=%b wa=%0d wd=%0h", g, we, wa, wd);
    end
  endtask

  task automatic test_zero();
    int g;
    valid = 3'b010;
    a[1] = 5'd0;
    d[1] = 32'hFFFF_FFFF;
    #1;
    g = pick(valid, m_last);
    n_cmp++; if (ready !== 3'b010) begin n_bad++; $display("FAIL zero_ready: got %b want 010", ready); end
    model_accept(g);
    step();
    valid = '0;
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL zero_we: got %b want 0", we); end
    $display("zero: ready granted to 1, we=%b", we);
    #1;
    n_cmp++; if (ready !== '0) begin n_bad++; $display("FAIL idle_ready: got %b want 000", ready); end
    model_accept(-1);
    step();
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL idle_we: got %b want 0", we); end
    $display("idle: ready=%b we=%b", ready, we);
  endtask

  task automatic test_starvation();
    int g;
    int since;
    since = 0;
    for (int i = 0; i < N; i++) begin
      a[i] = 5'(20 + i);
      d[i] = $urandom;
    end
    for (int i = 0; i < 30; i++) begin
      valid = {1'b1, 2'($urandom_range(0, 3))};
      #1;
      g = pick(valid, m_last);
      n_cmp++;
      if (ready !== onehot(g)) begin
        n_bad++; $display("FAIL starve_ready%0d: got %b want %b", i, ready, onehot(g));
      end
      since = (ready[2] === 1'b1) ? 0 : since + 1;
      n_cmp++;
      if (since >= 3) begin
        n_bad++; $display("FAIL starve_bound%0d: got %0d cycles without grant want <3", i, since);
      end
      model_accept(g);
      step();
      n_cmp++;
      if (we !== m_we || (m_we && (wa !== m_wa || wd !== m_wd))) begin
        n_bad++; $display("FAIL starve_write%0d: got we=%b wa=%0d wd=%0h want %b/%0d/%0h", i, we, wa, wd, m_we, m_wa, m_wd);
      end
      $display("starvation: valid=%b grant=%0d we=%b wa=%0d", valid, g, we, wa);
    end
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < N; i++) begin
      valid[i] = 1'($urandom_range(0, 1));
      a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      d[i] = $urandom;
    end
    for (int c = 0; c < 200; c++) begin
      #1;
      g = pick(valid, m_last);
      n_cmp++;
      if (ready !== onehot(g)) begin
        n_bad++; $display("FAIL rand_ready%0d: got %b want %b", c, ready, onehot(g));
      end
      model_accept(g);
      step();
      n_cmp++;
      if (we !== m_we || (m_we && (wa !== m_wa || wd !== m_wd))) begin
        n_bad++; $display("FAIL rand_write%0d: got we=%b wa=%0d wd=%0h want %b/%0d/%0h", c, we, wa, wd, m_we, m_wa, m_wd);
      end
      $display("random: valid=%b grant=%0d we=%b wa=%0d wd=%0h", valid, g, we, wa, wd);
      for (int i = 0; i < N; i++) begin
        if (valid[i] && i != g) begin
          if ($urandom_range(0, 3) == 0) valid[i] = 1'b0;
        end else begin
          valid[i] = 1'($urandom_range(0, 1));
          a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          d[i] = $urandom;
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (17) step();
    n_cmp++; if (wa !== 5'd16 || we !== 1'b1) begin n_bad++; $display("FAIL midclear_pre: got we=%b wa=%0d want 1/16", we, wa); end
    rst = 1'b1;
    step();
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL midclear_we: got %b want 0", we); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midclear_busy: got %b want 1", busy); end
    $display("midclear: reset at counter 17, we=%b busy=%b", we, busy);
    rst = 1'b0;
    run_clear("reclear", '0);
  endtask

  initial begin
    test_reset();
    test_no_clear();
    test_clear();
    test_rotation();
    test_zero();
    test_starvation();
    test_random();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequences and shares the single write port of the 32×32 CPU register file between up to NUM_REQ writeback sources (ALU writeback, load writeback, debug/host poke). After reset it runs a clear sequence that writes zero to all 32 registers. It then grants one requester per cycle, round-robin, over a valid/ready handshake. It drives the register file's write address, write data and write enable from registered outputs and enforces $zero write suppression.

## Interface
- NUM_REQ, 3, number of write requesters (2..4)
- CLEAR_ON_RESET, 1, 1 = run 32-cycle zero-fill after reset; 0 = go straight to arbitration
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  NUM_REQ*5  packed destination register, requester i at [5i+4:5i]
- req_data  input  NUM_REQ*32  packed write data, requester i at [32i+31:32i]
- req_ready  output  NUM_REQ  one-hot grant; handshake completes when valid & ready
- rf_wa  output  5  register file write address
- rf_wd  output  32  register file write data
- rf_we  output  1  register file write enable
- busy  output  1  high while the clear sequence runs

## Operation
- FSM states: CLEAR and RUN.
  - rst forces CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - rst clears the clear counter to 0 and the round-robin pointer to NUM_REQ-1, so requester 0 has first priority.
- CLEAR:
  - Each cycle registers rf_we=1, rf_wa=ctr, rf_wd=0, then increments ctr.
  - After the write for ctr=31 is issued, the FSM moves to RUN.
  - req_ready is all zeros throughout CLEAR.
- RUN, arbitration:
  - Search req_valid starting at ptr+1 and wrapping modulo NUM_REQ.
  - The first valid requester found gets req_ready (combinational, one-hot; at most one bit high).
  - On the handshake, ptr takes the granted index.
  - With no valid requesters, req_ready=0 and ptr holds.
- RUN, write issue:
  - A handshake in cycle N registers rf_wa/rf_wd from the granted requester and sets rf_we=1 in cycle N+1.
  - With no handshake, rf_we=0 in N+1; rf_wa/rf_wd hold their previous values.
- $zero rule: a handshake with req_addr=0 is accepted (ready asserts and the pointer advances) but rf_we stays 0.
- Requester obligations:
  - Hold valid, addr and data stable until ready is sampled high.
  - Valid may drop without a handshake; the arbiter keeps no per-requester state.
- Same-address writes from different requesters complete in grant order; the later grant wins.

## Timing
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, req_ready=0.
  - busy=1 while rst is high if CLEAR_ON_RESET=1, else 0.
- Clear sequence:
  - First edge with rst low: rf_we=1, rf_wa=0.
  - 32 consecutive writes cover addresses 0..31.
  - busy falls in the cycle rf_wa=31 is presented; req_ready may assert in that same cycle.
  - The first arbitrated write can appear one cycle later, with no gap or overlap.
- Latency: one cycle from handshake to rf_we.
- Throughput: one write per cycle, sustained.
- Starvation bound: a continuously valid requester is granted within NUM_REQ cycles.
- rst asserted mid-clear or mid-RUN:
  - Next cycle returns to the reset state; the clear restarts at address 0.
  - The write registered in the cycle rst is sampled is dropped (rf_we=0).
- Simultaneous rst and req_valid: no handshake; req_ready=0.

## Structure
- Shared package/header constants: REG_ADDR_W=5, REG_DATA_W=32, REG_COUNT=32, ZERO_REG=0, and the FSM state encoding (CLEAR=0, RUN=1).
- One sub-module, rr_arbiter:
  - Inputs: NUM_REQ, req vector, pointer.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register lives in the top.
- The top holds the FSM, clear counter, pointer and output registers.

## Test plan
- Reset then release, CLEAR_ON_RESET=1:
  - rf_we=1 for exactly 32 cycles with rf_wa 0..31 and rf_wd=0.
  - busy falls the cycle rf_wa=31; req_ready stays 0 while busy=1.
- RUN, all three valid continuously, addresses 5/6/7, data 0xA/0xB/0xC:
  - Grants rotate 0,1,2,0,…
  - rf_we stays high; rf_wa/rf_wd follow 5/0xA, 6/0xB, 7/0xC one cycle after each grant.
- Requester 1 alone, addr 0, data 0xFFFFFFFF:
  - req_ready[1]=1 and the handshake completes.
  - rf_we=0 next cycle.
- Requester 2 valid throughout, requesters 0 and 1 toggling randomly: requester 2 granted at least once every 3 cycles.
- rst pulsed for one cycle while the clear counter is at 17: the next write is rf_wa=0 and the full 32-write clear repeats.
- CLEAR_ON_RESET=0: busy=0 after reset; requester 0 valid in the first cycle gets req_ready that cycle and rf_we the next.
